// File: rtl/pll_reset_seq.sv
// pll_reset_seq: turns the PLL lock indication into staged, synchronous core resets.
//
// The asynchronous pll_locked input is synchronised through two flops and must stay high
// for SETTLE_CYCLES before stage 0 leaves reset. The remaining stages then release one at a
// time, STAGE_GAP cycles apart, in ascending index order. Losing lock re-asserts every
// stage at once and bumps a saturating debug counter. soft_rst reruns the settle period
// without counting a loss.
//
// Ports:
//   clk             - core clock (PLL outclk_0)
//   rst             - asynchronous, active-high master reset
//   pll_locked      - PLL lock indication, asynchronous to clk
//   soft_rst        - single-cycle synchronous request to rerun the sequence
//   stage_rst       - active-high stage resets, bit 0 releases first
//   ready           - high once every stage is released
//   lock_loss_count - saturating count of lock-loss events
module pll_reset_seq #(
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned STAGE_GAP     = 16,
  parameter int unsigned NUM_STAGES    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic                  soft_rst,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  ready,
  output logic [7:0]            lock_loss_count
);

  localparam int unsigned MaxCnt = (SETTLE_CYCLES > STAGE_GAP) ? SETTLE_CYCLES : STAGE_GAP;
  localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;
  localparam int unsigned IdxW   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast    = CntW'(STAGE_GAP - 1);
  localparam logic [IdxW-1:0] LastStage  = IdxW'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    StWaitLock,
    StSettle,
    StRelease,
    StRun
  } state_e;

  state_e          state_q;
  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q;
  logic [IdxW-1:0] stage_idx_q;
  logic            locked_s;

  assign locked_s = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q          <= 2'b00;
      state_q         <= StWaitLock;
      cnt_q           <= '0;
      stage_idx_q     <= '0;
      stage_rst       <= '1;
      ready           <= 1'b0;
      lock_loss_count <= 8'd0;
    end else begin
      sync_q <= {sync_q[0], pll_locked};

      if (state_q == StWaitLock) begin
        // soft_rst has nothing to restart while we are still waiting for lock.
        stage_rst <= '1;
        ready     <= 1'b0;
        cnt_q     <= '0;
        if (locked_s) begin
          state_q <= StSettle;
        end
      end else if (!locked_s) begin
        // Lock loss takes priority over a coincident soft_rst.
        stage_rst <= '1;
        ready     <= 1'b0;
        cnt_q     <= '0;
        state_q   <= StWaitLock;
        if (lock_loss_count != 8'hff) begin
          lock_loss_count <= lock_loss_count + 8'd1;
        end
      end else if (soft_rst) begin
        stage_rst <= '1;
        ready     <= 1'b0;
        cnt_q     <= '0;
        state_q   <= StSettle;
      end else begin
        unique case (state_q)
          StSettle: begin
            if (cnt_q == SettleLast) begin
              stage_rst[0] <= 1'b0;
              cnt_q        <= '0;
              stage_idx_q  <= IdxW'(1);
              if (NUM_STAGES == 1) begin
                ready   <= 1'b1;
                state_q <= StRun;
              end else begin
                state_q <= StRelease;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StRelease: begin
            if (cnt_q == GapLast) begin
              stage_rst[stage_idx_q] <= 1'b0;
              cnt_q                  <= '0;
              stage_idx_q            <= stage_idx_q + 1'b1;
              if (stage_idx_q == LastStage) begin
                ready   <= 1'b1;
                state_q <= StRun;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StRun: begin
            stage_rst <= '0;
            ready     <= 1'b1;
          end
          default: begin
            state_q <= StWaitLock;
          end
        endcase
      end
    end
  end

endmodule
